// File: rtl/dual_half_word_ram_pkg.sv
// Shared constants for the dual-port half-word text RAM.
package dual_half_word_ram_pkg;

  // Width of one stored half-word and of one byte lane.
  localparam int HWORD_W = 16;
  localparam int BYTE_W  = HWORD_W / 2;

  // Byte-lane write enables: bit0 is the low byte, bit1 the high byte.
  localparam logic [1:0] BE_LO  = 2'b01;
  localparam logic [1:0] BE_HI  = 2'b10;
  localparam logic [1:0] BE_ALL = 2'b11;

  // Default depth: one half-word per 80x30 text cell.
  localparam int TEXT_RAM_HWORDS = 80 * 30;

endpackage : dual_half_word_ram_pkg

// File: rtl/dual_half_word_ram_byte_lane.sv
// One 8-bit byte lane: single synchronous write port, two combinational
// read ports; out-of-range indices read as zero and never write.
module byte_lane_ram
  import dual_half_word_ram_pkg::*;
#(
  parameter int DEPTH = TEXT_RAM_HWORDS,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [IDX_W-1:0]  widx,
  input  logic [BYTE_W-1:0] wdata,
  input  logic [IDX_W-1:0]  ridx_a,
  output logic [BYTE_W-1:0] rdata_a,
  input  logic [IDX_W-1:0]  ridx_b,
  output logic [BYTE_W-1:0] rdata_b
);

  // Depth widened by one bit so a power-of-two DEPTH still fits.
  localparam logic [IDX_W:0] DEPTH_X = (IDX_W + 1)'(DEPTH);

  // Storage starts cleared; reset never touches it.
  logic [BYTE_W-1:0] mem_q [DEPTH] = '{default: '0};

  logic wr_en_d;
  logic rd_ok_a;
  logic rd_ok_b;

  // Decide whether this edge writes and whether each read index is in range.
  always_comb begin
    wr_en_d = we && ({1'b0, widx} < DEPTH_X);
    rd_ok_a = ({1'b0, ridx_a} < DEPTH_X);
    rd_ok_b = ({1'b0, ridx_b} < DEPTH_X);
  end

  // Asynchronous reads; out-of-range addresses return zero.
  always_comb begin
    rdata_a = '0;
    rdata_b = '0;
    if (rd_ok_a) rdata_a = mem_q[ridx_a];
    if (rd_ok_b) rdata_b = mem_q[ridx_b];
  end

  // Synchronous write, suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (!rst && wr_en_d) begin
      mem_q[widx] <= wdata;
    end
  end

endmodule : byte_lane_ram

// File: rtl/dual_half_word_ram.sv
// Byte-addressed, little-endian half-word RAM. Port 1 reads and writes with
// per-byte enables; port 2 only reads. Both reads are combinational.
module dual_half_word_ram
  import dual_half_word_ram_pkg::*;
#(
  parameter int SIZE_HWORDS = TEXT_RAM_HWORDS,
  parameter int ADDR_WIDTH  = $clog2(SIZE_HWORDS) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr_1,
  input  logic [HWORD_W-1:0]    wdata_1,
  input  logic [1:0]            wenable_1,
  output logic [HWORD_W-1:0]    rdata_1,
  input  logic [ADDR_WIDTH-1:0] addr_2,
  output logic [HWORD_W-1:0]    rdata_2
);

  localparam int IDX_W = ADDR_WIDTH - 1;

  logic [IDX_W-1:0]  idx_1;
  logic [IDX_W-1:0]  idx_2;
  logic              we_lo;
  logic              we_hi;
  logic [BYTE_W-1:0] rd1_lo, rd1_hi, rd2_lo, rd2_hi;
  logic              unused_addr_lsb;

  // Drop the byte-select bit: odd addresses hit the containing half-word.
  always_comb begin
    idx_1           = addr_1[ADDR_WIDTH-1:1];
    idx_2           = addr_2[ADDR_WIDTH-1:1];
    we_lo           = (wenable_1 & BE_LO) != 2'b00;
    we_hi           = (wenable_1 & BE_HI) != 2'b00;
    unused_addr_lsb = addr_1[0] ^ addr_2[0];
  end

  byte_lane_ram #(.DEPTH(SIZE_HWORDS), .IDX_W(IDX_W)) u_lane_lo (
    .clk    (clk),
    .rst    (rst),
    .we     (we_lo),
    .widx   (idx_1),
    .wdata  (wdata_1[BYTE_W-1:0]),
    .ridx_a (idx_1),
    .rdata_a(rd1_lo),
    .ridx_b (idx_2),
    .rdata_b(rd2_lo)
  );

  byte_lane_ram #(.DEPTH(SIZE_HWORDS), .IDX_W(IDX_W)) u_lane_hi (
    .clk    (clk),
    .rst    (rst),
    .we     (we_hi),
    .widx   (idx_1),
    .wdata  (wdata_1[HWORD_W-1:BYTE_W]),
    .ridx_a (idx_1),
    .rdata_a(rd1_hi),
    .ridx_b (idx_2),
    .rdata_b(rd2_hi)
  );

  // Reassemble half-words: even byte in [7:0], odd byte in [15:8].
  always_comb begin
    rdata_1 = {rd1_hi, rd1_lo};
    rdata_2 = {rd2_hi, rd2_lo};
  end

endmodule : dual_half_word_ram

// File: tb/tb_dual_half_word_ram.sv
// Self-checking bench for dual_half_word_ram: directed vector table plus
// randomized traffic against a byte-array reference model.
module tb_dual_half_word_ram;

  localparam int SIZE = 2400;
  localparam int AW   = $clog2(SIZE) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] addr_1;
  logic [15:0]   wdata_1;
  logic [1:0]    wenable_1;
  logic [15:0]   rdata_1;
  logic [AW-1:0] addr_2;
  logic [15:0]   rdata_2;

  int n_checks = 0;
  int n_errors = 0;

  // Reference: plain byte array, little-endian.
  logic [7:0] mdl [2*SIZE];

  always #5 clk = ~clk;

  dual_half_word_ram dut (
    .clk      (clk),
    .rst      (rst),
    .addr_1   (addr_1),
    .wdata_1  (wdata_1),
    .wenable_1(wenable_1),
    .rdata_1  (rdata_1),
    .addr_2   (addr_2),
    .rdata_2  (rdata_2)
  );

  typedef struct {
    logic          rst;
    logic [AW-1:0] a1;
    logic [15:0]   wd;
    logic [1:0]    we;
    logic [AW-1:0] a2;
    logic [15:0]   r1_pre;
    logic [15:0]   r1_post;
    logic [15:0]   r2_post;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_read(input logic [AW-1:0] a);
    int idx;
    idx = int'(a) / 2;
    if (idx >= SIZE) return 16'h0000;
    return {mdl[2*idx+1], mdl[2*idx]};
  endfunction

  task automatic model_write(input logic r, input logic [AW-1:0] a,
                             input logic [15:0] d, input logic [1:0] we);
    int idx;
    idx = int'(a) / 2;
    if (!r && idx < SIZE) begin
      if (we[0]) mdl[2*idx]   = d[7:0];
      if (we[1]) mdl[2*idx+1] = d[15:8];
    end
  endtask

  initial begin
    for (int i = 0; i < 2*SIZE; i++) mdl[i] = 8'h00;

    rst       = 1'b1;
    addr_1    = '0;
    addr_2    = AW'(2*(SIZE-1));
    wdata_1   = 16'h0000;
    wenable_1 = 2'b00;
    #1;
    chk("init_r1", rdata_1, 16'h0000);
    chk("init_r2", rdata_2, 16'h0000);

    //          rst   a1                wd        we     a2                pre       post_r1   post_r2
    vecs[0] = '{1'b1, AW'(4),           16'hDEAD, 2'b11, AW'(4),           16'h0000, 16'h0000, 16'h0000};
    vecs[1] = '{1'b0, AW'(10),          16'h1F41, 2'b11, AW'(10),          16'h0000, 16'h1F41, 16'h1F41};
    vecs[2] = '{1'b0, AW'(10),          16'hAABB, 2'b01, AW'(10),          16'h1F41, 16'h1FBB, 16'h1FBB};
    vecs[3] = '{1'b0, AW'(10),          16'hCC00, 2'b10, AW'(11),          16'h1FBB, 16'hCCBB, 16'hCCBB};
    vecs[4] = '{1'b0, AW'(11),          16'h1234, 2'b11, AW'(10),          16'hCCBB, 16'h1234, 16'h1234};
    vecs[5] = '{1'b0, AW'(10),          16'h9999, 2'b00, AW'(11),          16'h1234, 16'h1234, 16'h1234};
    vecs[6] = '{1'b0, AW'(2*(SIZE-1)),  16'hFFFF, 2'b11, AW'(2*SIZE-1),    16'h0000, 16'hFFFF, 16'hFFFF};
    vecs[7] = '{1'b0, AW'(2*SIZE),      16'h5A5A, 2'b11, AW'(0),           16'h0000, 16'h0000, 16'h0000};
    vecs[8] = '{1'b0, AW'(8190),        16'h7777, 2'b11, AW'(2*SIZE),      16'h0000, 16'h0000, 16'h0000};
    vecs[9] = '{1'b0, AW'(1),           16'h0000, 2'b00, AW'(4),           16'h0000, 16'h0000, 16'h0000};

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rst = vecs[i].rst; addr_1 = vecs[i].a1; wdata_1 = vecs[i].wd;
      wenable_1 = vecs[i].we; addr_2 = vecs[i].a2;
      #1;
      chk($sformatf("vec%0d_pre", i), rdata_1, vecs[i].r1_pre);
      @(posedge clk);
      model_write(rst, addr_1, wdata_1, wenable_1);
      #1;
      chk($sformatf("vec%0d_r1", i), rdata_1, vecs[i].r1_post);
      chk($sformatf("vec%0d_r2", i), rdata_2, vecs[i].r2_post);
    end

    // Reset held across several edges with writes pending, then released.
    @(negedge clk);
    rst = 1'b1; addr_1 = AW'(20); wdata_1 = 16'h4321; wenable_1 = 2'b11; addr_2 = AW'(20);
    repeat (3) @(posedge clk);
    #1;
    chk("rsthold_r1", rdata_1, 16'h0000);
    chk("rsthold_r2", rdata_2, 16'h0000);
    chk("rsthold_keep", model_read(AW'(10)), 16'h1234);
    @(negedge clk);
    chk("rsthold_r2_old", rdata_2, 16'h0000);
    rst = 1'b0;
    @(posedge clk);
    model_write(rst, addr_1, wdata_1, wenable_1);
    #1;
    chk("rstrel_r1", rdata_1, 16'h4321);
    chk("rstrel_r2", rdata_2, 16'h4321);

    // Randomized traffic; port 2 often aliases port 1 to hit read-during-write.
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      rst       = ($urandom_range(0, 19) == 0);
      addr_1    = ($urandom_range(0, 9) == 0) ? AW'($urandom) : AW'($urandom_range(0, 2*SIZE+7));
      wdata_1   = 16'($urandom);
      wenable_1 = 2'($urandom);
      case ($urandom_range(0, 3))
        0:       addr_2 = addr_1;
        1:       addr_2 = addr_1 ^ AW'(1);
        default: addr_2 = AW'($urandom_range(0, 2*SIZE+7));
      endcase
      #1;
      chk("rnd_pre_r1", rdata_1, model_read(addr_1));
      chk("rnd_pre_r2", rdata_2, model_read(addr_2));
      @(posedge clk);
      model_write(rst, addr_1, wdata_1, wenable_1);
      #1;
      chk("rnd_post_r1", rdata_1, model_read(addr_1));
      chk("rnd_post_r2", rdata_2, model_read(addr_2));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_dual_half_word_ram

// File: doc/dual_half_word_ram.md
Name: dual_half_word_ram

Overview:
- Byte-addressed RAM organised as SIZE_HWORDS 16-bit half-words.
- Port 1 is read/write with per-byte write enables. Port 2 is read-only.
- Writes are synchronous to one clock. Both read ports are combinational (asynchronous).
- Used as the text RAM of the video unit: the CPU uses port 1, the character scan-out uses port 2.

Parameters:
- SIZE_HWORDS, default 2400, number of 16-bit half-words stored (80x30 text cells).
- ADDR_WIDTH, default $clog2(SIZE_HWORDS)+1, byte-address width. Derived; do not override.

Ports:
- clk  in  1  single clock; all writes and the reset act on its rising edge.
- rst  in  1  synchronous, active-high reset.
- addr_1  in  ADDR_WIDTH  port-1 byte address.
- wdata_1  in  16  port-1 write data; [7:0] is the low byte, [15:8] the high byte.
- wenable_1  in  2  port-1 byte write enables; bit0 covers wdata_1[7:0], bit1 covers wdata_1[15:8].
- rdata_1  out  16  port-1 read data, combinational from addr_1.
- addr_2  in  ADDR_WIDTH  port-2 byte address (read-only).
- rdata_2  out  16  port-2 read data, combinational from addr_2.

Behaviour:
- Addressing:
  - Half-word index = addr[ADDR_WIDTH-1:1]. addr[0] is ignored, so odd addresses access the containing aligned half-word.
  - Little-endian: byte 2k is bits [7:0] of half-word k; byte 2k+1 is bits [15:8].
- Storage initialisation: every half-word is 16'h0000 at time zero.
- Reset:
  - rst does not clear memory contents.
  - While rst=1, all writes are suppressed.
  - Reads remain combinational and valid during reset.
  - rdata_1 and rdata_2 have no registered reset value; they always reflect the current contents.
- Write: on rising clk, with rst=0 and index < SIZE_HWORDS:
  - if wenable_1[0], mem[idx][7:0] <= wdata_1[7:0];
  - if wenable_1[1], mem[idx][15:8] <= wdata_1[15:8].
  - wenable_1 = 2'b00 means no write.
- Read:
  - rdata_1 = mem[addr_1 idx]; rdata_2 = mem[addr_2 idx]. Zero latency, no clock involvement.
- Out of range (index >= SIZE_HWORDS): reads return 16'h0000 and writes are ignored. Applies to both ports.
- Read-during-write (either port, same index): rdata shows the old value until the clk edge and the new value immediately after it. There is no write-through within the cycle.
- Partial write: the unenabled byte keeps its previous value.
- Port 2 may address any index simultaneously with port 1 with no conflict; port 2 never writes.

Decomposition:
- Shared package: the half-word width constant (16), byte-lane enable constants (BE_LO = 2'b01, BE_HI = 2'b10, BE_ALL = 2'b11), and the default text-RAM size (80*30).
- One natural sub-module, byte_lane_ram:
  - 8-bit wide, SIZE_HWORDS deep, one write enable, two combinational read ports.
  - Instantiated twice, once for the low lane and once for the high lane.

Test Plan:
- Init/reset:
  - At t=0, read addr_1=0, addr_2=2*(SIZE_HWORDS-1) -> both rdata 16'h0000.
  - Hold rst=1 with wenable_1=2'b11, addr_1=4, wdata_1=16'hDEAD -> rdata_1 stays 16'h0000 after the edge.
- Full write and dual read: rst=0, addr_1=10, wdata_1=16'h1F41, wenable_1=2'b11, one edge -> rdata_1=16'h1F41, and addr_2=10 gives rdata_2=16'h1F41. Before the edge, rdata_1 is 16'h0000.
- Byte enables: after the previous write, addr_1=10, wdata_1=16'hAABB, wenable_1=2'b01 -> 16'h1FBB. Then wenable_1=2'b10 with wdata_1=16'hCC00 -> 16'hCCBB.
- Odd address: addr_1=11, wdata_1=16'h1234, wenable_1=2'b11 -> addr_2=10 reads 16'h1234, and addr_1=11 reads 16'h1234.
- Bounds: write 16'hFFFF at addr_1=2*(SIZE_HWORDS-1) -> reads back 16'hFFFF. Write at addr_1=2*SIZE_HWORDS -> reads return 16'h0000, and index 0 is unchanged.
- Stress: random interleaved port-1 writes and reads and port-2 reads against a byte-array model over 1000 cycles -> zero mismatches, including same-index port-2 reads in the cycle of a write (old value before the edge, new after).
